// File: rtl/sudoku_pkg.sv
// Shared field layout, state encoding and edit helper for the Sudoku board editor.
package sudoku_pkg;
  localparam int WORD_W    = 24;
  localparam int NUM_ROWS  = 4;
  localparam int PROT_LSB  = 20;
  localparam int BLANK_LSB = 16;
  localparam int DIGIT_W   = 4;
  localparam int ROW_W     = 2;
  localparam int COL_W     = 2;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_ACK, S_LOAD} state_e;

  // Protect bits pass through untouched; only the digit nibble and blank flag change.
  function automatic logic [WORD_W-1:0] edit_word(input logic [WORD_W-1:0] w,
                                                  input logic [COL_W-1:0]  col,
                                                  input logic              op,
                                                  input logic [DIGIT_W-1:0] dig);
    logic [WORD_W-1:0] r;
    r = w;
    r[int'(col)*DIGIT_W +: DIGIT_W] = (op == OP_CLEAR) ? '0 : dig;
    r[BLANK_LSB + int'(col)]        = (op == OP_CLEAR);
    return r;
  endfunction
endpackage

// File: rtl/cursor_ctrl.sv
// Wrap-around 4x4 board cursor; opposing pulses in one cycle cancel.
module cursor_ctrl
  import sudoku_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             up_i,
  input  logic             down_i,
  input  logic             left_i,
  input  logic             right_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (up_i && !down_i)         row_d = row_q - 1'b1;
    else if (down_i && !up_i)    row_d = row_q + 1'b1;
    if (left_i && !right_i)      col_d = col_q - 1'b1;
    else if (right_i && !left_i) col_d = col_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
endmodule

// File: rtl/board_editor.sv
// Sudoku game-state store with cursor, protected read-modify-write edits and board reload.
// Define UNDO_EN to add the UndoReq port and a one-entry undo record.
module board_editor
  import sudoku_pkg::*;
#(
  parameter logic [NUM_ROWS*WORD_W-1:0] PUZZLE_INIT = 96'h0F0000_0F0000_0F0000_0F0000,
  parameter int                         MAX_DIGIT   = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               MoveUp,
  input  logic               MoveDown,
  input  logic               MoveLeft,
  input  logic               MoveRight,
  output logic [ROW_W-1:0]   CursorRow,
  output logic [COL_W-1:0]   CursorCol,
  input  logic               EditReq,
  input  logic               EditOp,
  input  logic [DIGIT_W-1:0] EditDigit,
  input  logic               LoadReq,
`ifdef UNDO_EN
  input  logic               UndoReq,
`endif
  output logic               EditBusy,
  output logic               EditAck,
  output logic               EditRejected,
  input  logic [ROW_W-1:0]   RamAddr,
  output logic [WORD_W-1:0]  RamDat
);
  state_e               state_q, state_d;
  logic [WORD_W-1:0]    store_q [NUM_ROWS];
  logic [WORD_W-1:0]    shadow_q;
  logic [ROW_W-1:0]     row_q, load_cnt_q;
  logic [COL_W-1:0]     col_q;
  logic                 op_q, rej_q, rej_d;
  logic [DIGIT_W-1:0]   dig_q;
  logic [WORD_W-1:0]    wr_word;
  logic                 acc_load, acc_edit;
  logic                 rd_prot, dig_bad;
`ifdef UNDO_EN
  logic                 acc_undo, is_undo_q, undo_vld_q;
  logic [ROW_W-1:0]     undo_row_q;
  logic [WORD_W-1:0]    undo_word_q;
`endif

  cursor_ctrl u_cursor (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .up_i   (MoveUp),
    .down_i (MoveDown),
    .left_i (MoveLeft),
    .right_i(MoveRight),
    .row_o  (CursorRow),
    .col_o  (CursorCol)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Requests are only looked at in IDLE; anything arriving while busy is dropped.
  always_comb begin
    state_d  = state_q;
    acc_load = 1'b0;
    acc_edit = 1'b0;
`ifdef UNDO_EN
    acc_undo = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (LoadReq) begin
          acc_load = 1'b1;
          state_d  = S_LOAD;
        end else if (EditReq) begin
          acc_edit = 1'b1;
          state_d  = S_READ;
        end
`ifdef UNDO_EN
        else if (UndoReq) begin
          acc_undo = 1'b1;
          state_d  = S_READ;
        end
`endif
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      S_LOAD:  if (load_cnt_q == ROW_W'(NUM_ROWS-1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_prot = store_q[row_q][PROT_LSB + int'(col_q)];
  assign dig_bad = (dig_q == '0) || (int'(dig_q) > MAX_DIGIT);

  always_comb begin
    rej_d   = rd_prot | ((op_q == OP_WRITE) & dig_bad);
    wr_word = edit_word(shadow_q, col_q, op_q, dig_q);
`ifdef UNDO_EN
    if (is_undo_q) begin
      rej_d   = ~undo_vld_q;
      wr_word = undo_word_q;
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ROWS; i++) store_q[i] <= PUZZLE_INIT[i*WORD_W +: WORD_W];
      shadow_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      op_q       <= OP_WRITE;
      dig_q      <= '0;
      rej_q      <= 1'b0;
      load_cnt_q <= '0;
    end else begin
      if (acc_edit) begin
        row_q <= CursorRow;
        col_q <= CursorCol;
        op_q  <= EditOp;
        dig_q <= EditDigit;
      end
`ifdef UNDO_EN
      if (acc_undo) row_q <= undo_row_q;
`endif
      if (acc_load) load_cnt_q <= '0;
      case (state_q)
        S_READ: begin
          shadow_q <= store_q[row_q];
          rej_q    <= rej_d;
        end
        S_WRITE: if (!rej_q) store_q[row_q] <= wr_word;
        S_LOAD: begin
          store_q[load_cnt_q] <= PUZZLE_INIT[int'(load_cnt_q)*WORD_W +: WORD_W];
          load_cnt_q          <= load_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef UNDO_EN
  // An accepted edit arms the record with the pre-edit word; a successful undo disarms it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_undo_q   <= 1'b0;
      undo_vld_q  <= 1'b0;
      undo_row_q  <= '0;
      undo_word_q <= '0;
    end else begin
      if (acc_edit) is_undo_q <= 1'b0;
      if (acc_undo) is_undo_q <= 1'b1;
      if (acc_load) undo_vld_q <= 1'b0;
      if (state_q == S_WRITE && !rej_q) begin
        if (is_undo_q) begin
          undo_vld_q <= 1'b0;
        end else begin
          undo_vld_q  <= 1'b1;
          undo_row_q  <= row_q;
          undo_word_q <= shadow_q;
        end
      end
    end
  end
`endif

  assign EditBusy     = (state_q != S_IDLE);
  assign EditAck      = (state_q == S_ACK);
  assign EditRejected = EditAck & rej_q;
  assign RamDat       = store_q[RamAddr];
endmodule

// File: tb/tb_board_editor.sv
// Randomized bench for board_editor: two instances (default and partly protected puzzle) vs a board model.
module tb_board_editor;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST, MoveUp, MoveDown, MoveLeft, MoveRight, EditReq, EditOp, LoadReq;
  logic [3:0] EditDigit;
  logic [1:0] RamAddr;
`ifdef UNDO_EN
  logic       UndoReq;
`endif
  logic [1:0]  crow, ccol, crow_p, ccol_p;
  logic        busy, ack, rej, busy_p, ack_p, rej_p;
  logic [23:0] dat, dat_p;

  localparam logic [95:0] INIT_P = {24'h8F0000, 24'h320040, 24'h0F0000, 24'h100002};

  board_editor dut (
    .CLK(CLK), .nRST(nRST), .MoveUp(MoveUp), .MoveDown(MoveDown), .MoveLeft(MoveLeft),
    .MoveRight(MoveRight), .CursorRow(crow), .CursorCol(ccol), .EditReq(EditReq),
    .EditOp(EditOp), .EditDigit(EditDigit), .LoadReq(LoadReq),
`ifdef UNDO_EN
    .UndoReq(UndoReq),
`endif
    .EditBusy(busy), .EditAck(ack), .EditRejected(rej), .RamAddr(RamAddr), .RamDat(dat));

  board_editor #(.PUZZLE_INIT(INIT_P)) dut_p (
    .CLK(CLK), .nRST(nRST), .MoveUp(MoveUp), .MoveDown(MoveDown), .MoveLeft(MoveLeft),
    .MoveRight(MoveRight), .CursorRow(crow_p), .CursorCol(ccol_p), .EditReq(EditReq),
    .EditOp(EditOp), .EditDigit(EditDigit), .LoadReq(LoadReq),
`ifdef UNDO_EN
    .UndoReq(UndoReq),
`endif
    .EditBusy(busy_p), .EditAck(ack_p), .EditRejected(rej_p), .RamAddr(RamAddr), .RamDat(dat_p));

  int checks = 0;
  int errors = 0;

  // Reference model: board contents per instance, cursor, undo record.
  logic [23:0] init_rows [2][4];
  logic [23:0] mb [2][4];
  int          mrow, mcol;
  bit          uv [2];
  int          urow [2];
  logic [23:0] uword [2];

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      init_rows[0][r] = 24'h0F0000;
      init_rows[1][r] = INIT_P[r*24 +: 24];
      mb[0][r] = init_rows[0][r];
      mb[1][r] = init_rows[1][r];
    end
    mrow = 0; mcol = 0;
    uv[0] = 0; uv[1] = 0;
  endtask

  task automatic model_apply(input int k, input bit undo, input bit op, input int dig, output bit rj);
    logic [23:0] w;
    if (undo) begin
      rj = !uv[k];
      if (!rj) begin
        mb[k][urow[k]] = uword[k];
        uv[k] = 0;
      end
    end else begin
      w  = mb[k][mrow];
      rj = w[20+mcol] || (op == 1'b0 && (dig < 1 || dig > 4));
      if (!rj) begin
        uv[k] = 1; urow[k] = mrow; uword[k] = w;
        w = w & ~(24'hF << (4*mcol));
        if (op == 1'b0) begin
          w = w | (24'(dig) << (4*mcol));
          w[16+mcol] = 1'b0;
        end else begin
          w[16+mcol] = 1'b1;
        end
        mb[k][mrow] = w;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic read_row(input int r, output logic [23:0] a, output logic [23:0] b);
    RamAddr = 2'(r);
    #1;
    a = dat;
    b = dat_p;
  endtask

  task automatic move(input bit u, input bit d, input bit l, input bit r);
    MoveUp = u; MoveDown = d; MoveLeft = l; MoveRight = r;
    tick();
    MoveUp = 0; MoveDown = 0; MoveLeft = 0; MoveRight = 0;
    if (u && !d) mrow = (mrow + 3) % 4;
    if (d && !u) mrow = (mrow + 1) % 4;
    if (l && !r) mcol = (mcol + 3) % 4;
    if (r && !l) mcol = (mcol + 1) % 4;
  endtask

  // Drives one edit/undo request and records what both instances report over the next 5 cycles.
  task automatic run_req(input bit undo, input bit op, input int dig,
                         output int ack_k, output int acks, output int acks_p,
                         output bit rj, output bit rj_p, output bit busy_after);
    EditReq = !undo; EditOp = op; EditDigit = 4'(dig);
`ifdef UNDO_EN
    UndoReq = undo;
`endif
    tick();
    EditReq = 0;
`ifdef UNDO_EN
    UndoReq = 0;
`endif
    ack_k = -1; acks = 0; acks_p = 0; rj = 0; rj_p = 0; busy_after = 1;
    for (int k = 1; k <= 5; k++) begin
      if (ack)   begin acks++;   ack_k = k; rj = rej; end
      if (ack_p) begin acks_p++; rj_p = rej_p; end
      if (k == 4) busy_after = busy;
      if (k < 5) tick();
    end
  endtask

  task automatic check_boards(input string tag);
    logic [23:0] a, b;
    for (int r = 0; r < 4; r++) begin
      read_row(r, a, b);
      checks++;
      if (a !== mb[0][r]) begin
        errors++; $display("FAIL %s row%0d got %h expected %h", tag, r, a, mb[0][r]);
      end
      checks++;
      if (b !== mb[1][r]) begin
        errors++; $display("FAIL %s prot row%0d got %h expected %h", tag, r, b, mb[1][r]);
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] a, b;
    nRST = 0; MoveUp = 0; MoveDown = 0; MoveLeft = 0; MoveRight = 0;
    EditReq = 0; EditOp = 0; EditDigit = 0; LoadReq = 0; RamAddr = 0;
`ifdef UNDO_EN
    UndoReq = 0;
`endif
    model_reset();
    repeat (2) tick();
    nRST = 1;
    tick();
    for (int r = 0; r < 4; r++) begin
      read_row(r, a, b);
      checks++;
      if (a !== 24'h0F0000) begin errors++; $display("FAIL reset row%0d got %h expected 0f0000", r, a); end
    end
    check_boards("reset");
    checks++;
    if ({crow, ccol, busy, ack, rej} !== 7'b0) begin
      errors++; $display("FAIL reset outputs got %b expected 0", {crow, ccol, busy, ack, rej});
    end
  endtask

  task automatic test_write();
    int k, n, np; bit rj, rjp, ba, e0, e1; logic [23:0] a, b;
    model_apply(0, 0, 0, 3, e0);
    model_apply(1, 0, 0, 3, e1);
    run_req(0, 0, 3, k, n, np, rj, rjp, ba);
    checks++;
    if (k !== 3 || n !== 1 || ba !== 1'b0) begin
      errors++; $display("FAIL write_latency ack_cycle %0d acks %0d busy %b expected 3 1 0", k, n, ba);
    end
    checks++;
    if (rj !== 1'b0) begin errors++; $display("FAIL write_rej got %b expected 0", rj); end
    checks++;
    if (rjp !== 1'b1 || np !== 1) begin
      errors++; $display("FAIL protect_rej got %b acks %0d expected 1 1", rjp, np);
    end
    read_row(0, a, b);
    checks++;
    if (a !== 24'h0E0003 || b !== 24'h100002) begin
      errors++; $display("FAIL write_row0 got %h/%h expected 0e0003/100002", a, b);
    end
    check_boards("write");
  endtask

  task automatic test_range();
    int k, n, np; bit rj, rjp, ba, e0, e1;
    int digs [3] = '{0, 5, 0};
    for (int i = 0; i < 3; i++) begin
      model_apply(0, 0, (i == 2), digs[i], e0);
      model_apply(1, 0, (i == 2), digs[i], e1);
      run_req(0, (i == 2), digs[i], k, n, np, rj, rjp, ba);
      checks++;
      if (rj !== e0 || rjp !== e1 || n !== 1) begin
        errors++; $display("FAIL range%0d rej got %b/%b expected %b/%b", i, rj, rjp, e0, e1);
      end
    end
    checks++;
    if (mb[0][0] !== 24'h0F0000) begin errors++; $display("FAIL clear_model row0 %h", mb[0][0]); end
    check_boards("range_clear");
  endtask

  task automatic test_cursor();
    move(0, 0, 1, 0);
    checks++;
    if (ccol !== 2'd3 || crow !== 2'd0) begin
      errors++; $display("FAIL left_wrap got %0d,%0d expected 0,3", crow, ccol);
    end
    move(1, 1, 0, 0);
    checks++;
    if (crow !== 2'd0) begin errors++; $display("FAIL updown_cancel got %0d expected 0", crow); end
    move(1, 0, 0, 1);
    checks++;
    if (crow !== 2'd3 || ccol !== 2'd0 || crow_p !== 2'd3) begin
      errors++; $display("FAIL up_right_wrap got %0d,%0d expected 3,0", crow, ccol);
    end
    mrow = 3; mcol = 0;
  endtask

  task automatic test_busy_drop();
    int n; bit e0, e1;
    model_apply(0, 0, 0, 1, e0);
    model_apply(1, 0, 0, 1, e1);
    EditReq = 1; EditOp = 0; EditDigit = 4'd1;
    repeat (3) tick();
    EditReq = 0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (ack) n++;
      tick();
    end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL busy_drop acks got %0d expected 1", n); end
    check_boards("busy_drop");
  endtask

  task automatic test_reset_mid();
    move(0, 1, 0, 1);
    EditReq = 1; EditOp = 0; EditDigit = 4'd2;
    tick();
    EditReq = 0;
    tick();
    nRST = 0;
    #2;
    nRST = 1;
    model_reset();
    tick();
    check_boards("reset_mid");
    checks++;
    if ({crow, ccol, busy, ack} !== 6'b0) begin
      errors++; $display("FAIL reset_mid outputs got %b expected 0", {crow, ccol, busy, ack});
    end
  endtask

  task automatic test_load();
    int k, n, np, nb, na; bit rj, rjp, ba, e0, e1;
    model_apply(0, 0, 0, 4, e0);
    model_apply(1, 0, 0, 4, e1);
    run_req(0, 0, 4, k, n, np, rj, rjp, ba);
    LoadReq = 1; EditReq = 1; EditOp = 0; EditDigit = 4'd2;
    tick();
    LoadReq = 0; EditReq = 0;
    nb = 0; na = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy) nb++;
      if (ack || ack_p) na++;
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      mb[0][r] = init_rows[0][r];
      mb[1][r] = init_rows[1][r];
    end
    uv[0] = 0; uv[1] = 0;
    checks++;
    if (nb !== 4 || na !== 0) begin
      errors++; $display("FAIL load busy_cycles %0d acks %0d expected 4 0", nb, na);
    end
    check_boards("load");
  endtask

  task automatic test_random();
    int k, n, np, dig; bit rj, rjp, ba, e0, e1, op;
    for (int it = 0; it < 30; it++) begin
      for (int m = 0; m < int'($urandom_range(0, 2)); m++) begin
        logic [3:0] p;
        p = 4'($urandom_range(0, 15));
        move(p[0], p[1], p[2], p[3]);
      end
      checks++;
      if (crow !== 2'(mrow) || ccol !== 2'(mcol) || crow_p !== 2'(mrow) || ccol_p !== 2'(mcol)) begin
        errors++; $display("FAIL rnd_cursor got %0d,%0d expected %0d,%0d", crow, ccol, mrow, mcol);
      end
      op  = ($urandom_range(0, 3) == 0);
      dig = $urandom_range(0, 6);
      model_apply(0, 0, op, dig, e0);
      model_apply(1, 0, op, dig, e1);
      run_req(0, op, dig, k, n, np, rj, rjp, ba);
      checks++;
      if (k !== 3 || n !== 1 || np !== 1 || rj !== e0 || rjp !== e1) begin
        errors++;
        $display("FAIL rnd_edit%0d ack_cycle %0d rej %b/%b expected 3 %b/%b", it, k, rj, rjp, e0, e1);
      end
      check_boards("rnd");
    end
  endtask

`ifdef UNDO_EN
  task automatic test_undo();
    int k, n, np; bit rj, rjp, ba, e0, e1; logic [23:0] before;
    before = mb[0][mrow];
    model_apply(0, 0, 0, 2, e0);
    model_apply(1, 0, 0, 2, e1);
    run_req(0, 0, 2, k, n, np, rj, rjp, ba);
    for (int i = 0; i < 2; i++) begin
      model_apply(0, 1, 0, 0, e0);
      model_apply(1, 1, 0, 0, e1);
      run_req(1, 0, 0, k, n, np, rj, rjp, ba);
      checks++;
      if (k !== 3 || rj !== bit'(i) || rjp !== e1) begin
        errors++; $display("FAIL undo%0d ack_cycle %0d rej %b/%b expected 3 %0d/%b", i, k, rj, rjp, i, e1);
      end
    end
    checks++;
    if (mb[0][mrow] !== before) begin errors++; $display("FAIL undo_model %h expected %h", mb[0][mrow], before); end
    check_boards("undo");
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_range();
    test_cursor();
    test_busy_drop();
    test_reset_mid();
    test_load();
    test_random();
`ifdef UNDO_EN
    test_undo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
